// File: rtl/de_fe_pkg.sv
// Shared constants for the decode-side fetch-latch receiver: latch field layout,
// opcode constants and the register-usage decoder.
package de_fe_pkg;

    localparam int DBITS_DEF    = 32;
    localparam int INSTBITS_DEF = 32;
    localparam int CANARY_BITS  = 4;
    localparam logic [CANARY_BITS-1:0] CANARY_VALUE = 4'hA;
    localparam int FE_W_DEF     = INSTBITS_DEF + 3 * DBITS_DEF + CANARY_BITS;

    // Latch layout, MSB first: inst, pc, pcplus, inst_count, canary
    localparam int CANARY_LSB = 0;
    localparam int CANARY_MSB = CANARY_BITS - 1;
    localparam int COUNT_LSB  = CANARY_MSB + 1;
    localparam int COUNT_MSB  = COUNT_LSB + DBITS_DEF - 1;
    localparam int PCPLUS_LSB = COUNT_MSB + 1;
    localparam int PCPLUS_MSB = PCPLUS_LSB + DBITS_DEF - 1;
    localparam int PC_LSB     = PCPLUS_MSB + 1;
    localparam int PC_MSB     = PC_LSB + DBITS_DEF - 1;
    localparam int INST_LSB   = PC_MSB + 1;
    localparam int INST_MSB   = INST_LSB + INSTBITS_DEF - 1;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef struct packed {
        logic writes_rd;
        logic use_rs1;
        logic use_rs2;
    } reg_use_t;

    function automatic reg_use_t decode_use(input logic [6:0] opcode);
        reg_use_t u;
        u.writes_rd = (opcode != OP_STORE) && (opcode != OP_BRANCH);
        u.use_rs1   = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
        u.use_rs2   = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        return u;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// 32-entry register busy scoreboard; reads see a same-cycle writeback release,
// and a same-cycle set on the released register wins over the clear.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_en,
    input  logic [4:0]  clr_idx,
    input  logic        set_en,
    input  logic [4:0]  set_idx,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic [31:0] busy_vec
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] busy_eff;

    always_comb begin
        busy_eff = busy_q;
        if (clr_en) busy_eff[clr_idx] = 1'b0;
        busy_eff[0] = 1'b0;
        busy_d = busy_eff;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_rs1 = busy_eff[rs1_idx];
    assign busy_rs2 = busy_eff[rs2_idx];
    assign busy_vec = busy_q;

endmodule

// File: rtl/de_fe_receiver.sv
// Decode stage receiver: validates the fetch latch by canary, blocks on register
// hazards, and registers a valid-tagged decode latch for AGEX.
module de_fe_receiver
    import de_fe_pkg::*;
#(
    parameter int DBITS    = DBITS_DEF,
    parameter int INSTBITS = INSTBITS_DEF,
    parameter int FE_W     = INSTBITS + 3 * DBITS + CANARY_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FE_W-1:0]     fe_latch_in,
    input  logic                agex_stall,
    input  logic                agex_flush,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    output logic                de_stall_to_fe,
    output logic                de_valid_out,
    output logic [INSTBITS-1:0] de_inst_out,
    output logic [DBITS-1:0]    de_pc_out,
    output logic [DBITS-1:0]    de_pcplus_out,
    output logic [DBITS-1:0]    de_count_out,
    output logic [4:0]          de_rd_out,
    output logic                de_wr_out,
    output logic                canary_err,
    output logic [DBITS-1:0]    canary_err_pc,
    output logic [31:0]         busy_vec
);

    logic [INSTBITS-1:0]    f_inst;
    logic [DBITS-1:0]       f_pc, f_pcplus, f_count;
    logic [CANARY_BITS-1:0] f_canary;
    logic [4:0]             f_rd, f_rs1, f_rs2;
    reg_use_t               f_use;
    logic                   in_valid, bad_word, busy_rs1, busy_rs2, hazard, issue, set_en;

    assign f_inst   = fe_latch_in[INST_MSB:INST_LSB];
    assign f_pc     = fe_latch_in[PC_MSB:PC_LSB];
    assign f_pcplus = fe_latch_in[PCPLUS_MSB:PCPLUS_LSB];
    assign f_count  = fe_latch_in[COUNT_MSB:COUNT_LSB];
    assign f_canary = fe_latch_in[CANARY_MSB:CANARY_LSB];
    assign f_rd     = f_inst[11:7];
    assign f_rs1    = f_inst[19:15];
    assign f_rs2    = f_inst[24:20];
    assign f_use    = decode_use(f_inst[6:0]);

    // An all-zero word is an ordinary bubble, not a bus fault.
    assign in_valid = (f_canary == CANARY_VALUE);
    assign bad_word = (|fe_latch_in) && !in_valid;

    assign hazard = in_valid && ((f_use.use_rs1 && busy_rs1) || (f_use.use_rs2 && busy_rs2));
    assign issue  = in_valid && !hazard && !agex_stall && !agex_flush;
    assign set_en = issue && f_use.writes_rd && (f_rd != 5'd0);
    assign de_stall_to_fe = (hazard || agex_stall) && !agex_flush;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (reset),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .set_en  (set_en),
        .set_idx (f_rd),
        .rs1_idx (f_rs1),
        .rs2_idx (f_rs2),
        .busy_rs1(busy_rs1),
        .busy_rs2(busy_rs2),
        .busy_vec(busy_vec)
    );

    logic                valid_q, valid_d, wr_q, wr_d, err_q, err_d;
    logic [INSTBITS-1:0] inst_q, inst_d;
    logic [DBITS-1:0]    pc_q, pc_d, pcplus_q, pcplus_d, count_q, count_d, err_pc_q, err_pc_d;
    logic [4:0]          rd_q, rd_d;

    always_comb begin
        valid_d  = valid_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        pcplus_d = pcplus_q;
        count_d  = count_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        err_d    = err_q;
        err_pc_d = err_pc_q;
        if (agex_flush) begin
            valid_d = 1'b0;
        end else if (!agex_stall) begin
            valid_d = issue;
            if (issue) begin
                inst_d   = f_inst;
                pc_d     = f_pc;
                pcplus_d = f_pcplus;
                count_d  = f_count;
                rd_d     = f_rd;
                wr_d     = f_use.writes_rd && (f_rd != 5'd0);
            end
        end
        // Only the first bad word's PC is kept; the flag stays up until reset.
        if (bad_word && !err_q) begin
            err_d    = 1'b1;
            err_pc_d = f_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
            pcplus_q <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            err_pc_q <= '0;
        end else begin
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            pcplus_q <= pcplus_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            err_pc_q <= err_pc_d;
        end
    end

    assign de_valid_out  = valid_q;
    assign de_inst_out   = inst_q;
    assign de_pc_out     = pc_q;
    assign de_pcplus_out = pcplus_q;
    assign de_count_out  = count_q;
    assign de_rd_out     = rd_q;
    assign de_wr_out     = wr_q;
    assign canary_err    = err_q;
    assign canary_err_pc = err_pc_q;

endmodule

// File: tb/tb_de_fe_receiver.sv
// Directed bench for de_fe_receiver: a behavioural model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_de_fe_receiver;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [131:0] fe = '0;
    logic         agex_stall = 1'b0;
    logic         agex_flush = 1'b0;
    logic         wb_valid = 1'b0;
    logic [4:0]   wb_rd = 5'd0;

    logic         stall_o, valid_o, wr_o, err_o;
    logic [31:0]  inst_o, pc_o, pcplus_o, cnt_o, err_pc_o, busy_o;
    logic [4:0]   rd_o;

    int total = 0;
    int bad = 0;

    de_fe_receiver dut (
        .clk(clk), .reset(reset), .fe_latch_in(fe), .agex_stall(agex_stall),
        .agex_flush(agex_flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .de_stall_to_fe(stall_o), .de_valid_out(valid_o), .de_inst_out(inst_o),
        .de_pc_out(pc_o), .de_pcplus_out(pcplus_o), .de_count_out(cnt_o),
        .de_rd_out(rd_o), .de_wr_out(wr_o), .canary_err(err_o),
        .canary_err_pc(err_pc_o), .busy_vec(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [131:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] cnt, input logic [3:0] can);
        return {inst, pc, pc + 32'd4, cnt, can};
    endfunction

    // ---------------- behavioural model ----------------
    bit [31:0] m_busy = 0;
    bit        m_valid = 0, m_wr = 0, m_err = 0;
    bit [31:0] m_inst = 0, m_pc = 0, m_pcplus = 0, m_cnt = 0, m_err_pc = 0;
    bit [4:0]  m_rd = 0;

    function automatic bit reg_busy(input bit [4:0] r);
        if (r == 0) return 0;
        if (wb_valid && wb_rd == r) return 0;
        return m_busy[r];
    endfunction

    function automatic bit word_ok(input logic [131:0] w);
        return w[3:0] == 4'hA;
    endfunction

    function automatic bit hazard_now(input logic [131:0] w);
        bit [6:0] op;
        bit uses1, uses2;
        op = w[106:100];
        uses1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        uses2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return word_ok(w) && ((uses1 && reg_busy(w[119:115])) || (uses2 && reg_busy(w[124:120])));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_valid = 0; m_wr = 0; m_err = 0; m_inst = 0; m_pc = 0;
            m_pcplus = 0; m_cnt = 0; m_err_pc = 0; m_rd = 0;
        end else begin
            bit iss, writes;
            bit [6:0] op;
            bit [4:0] rd;
            op = fe[106:100];
            rd = fe[111:107];
            writes = !(op == 7'h23 || op == 7'h63);
            iss = word_ok(fe) && !hazard_now(fe) && !agex_stall && !agex_flush;
            if (fe != 0 && !word_ok(fe) && !m_err) begin
                m_err = 1; m_err_pc = fe[99:68];
            end
            if (agex_flush) m_valid = 0;
            else if (!agex_stall) begin
                m_valid = iss;
                if (iss) begin
                    m_inst = fe[131:100]; m_pc = fe[99:68]; m_pcplus = fe[67:36];
                    m_cnt = fe[35:4]; m_rd = rd; m_wr = writes && rd != 0;
                end
            end
            if (wb_valid) m_busy[wb_rd] = 0;
            if (iss && writes && rd != 0) m_busy[rd] = 1;
            m_busy[0] = 0;
        end
    end

    always @(negedge clk) begin
        check("stall", stall_o, (hazard_now(fe) || agex_stall) && !agex_flush);
        check("valid", valid_o, m_valid);
        check("inst", inst_o, m_inst);
        check("pc", pc_o, m_pc);
        check("pcplus", pcplus_o, m_pcplus);
        check("count", cnt_o, m_cnt);
        check("rd", rd_o, m_rd);
        check("wr", wr_o, m_wr);
        check("cerr", err_o, m_err);
        check("cerr_pc", err_pc_o, m_err_pc);
        check("busy", busy_o, m_busy);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        reset = 1'b1;
        cyc(5);
        check("rst_valid", valid_o, 0);
        check("rst_cerr", err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stall", stall_o, 0);

        // addi x5,x0,1
        fe = mk(32'h00100293, 32'h200, 32'd1, 4'hA);
        cyc();
        check("addi_valid", valid_o, 1);
        check("addi_pc", pc_o, 32'h200);
        check("addi_pcplus", pcplus_o, 32'h204);
        check("addi_rd", rd_o, 5);
        check("addi_wr", wr_o, 1);
        check("addi_busy5", busy_o[5], 1);

        // add x6,x5,x5 waits on x5
        fe = mk(32'h00528333, 32'h204, 32'd2, 4'hA);
        #1 check("add_stall", stall_o, 1);
        cyc();
        check("add_bubble", valid_o, 0);
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1 check("add_wb_release", stall_o, 0);
        cyc();
        wb_valid = 1'b0;
        check("add_valid", valid_o, 1);
        check("add_rd", rd_o, 6);
        check("add_busy65", busy_o[6:5], 2'b10);

        // addi x7,x0,3 with a same-cycle writeback of x7
        fe = mk(32'h00300393, 32'h208, 32'd3, 4'hA);
        wb_valid = 1'b1; wb_rd = 5'd7;
        cyc();
        wb_valid = 1'b0;
        check("setwins_busy7", busy_o[7], 1);

        // flush beats stall; addi x8 must not issue
        fe = mk(32'h00100413, 32'h20C, 32'd4, 4'hA);
        agex_flush = 1'b1; agex_stall = 1'b1;
        #1 check("flush_stall", stall_o, 0);
        cyc();
        agex_flush = 1'b0; agex_stall = 1'b0;
        check("flush_valid", valid_o, 0);
        check("flush_busy8", busy_o[8], 0);

        // sw x5,0(x0): no rd write
        fe = mk(32'h00502023, 32'h210, 32'd5, 4'hA);
        cyc();
        check("sw_wr", wr_o, 0);

        // stall holds the DE latch; addi x11 waits
        fe = mk(32'h00100593, 32'h214, 32'd6, 4'hA);
        agex_stall = 1'b1;
        cyc(2);
        check("hold_pc", pc_o, 32'h210);
        check("hold_busy11", busy_o[11], 0);
        agex_stall = 1'b0;
        cyc();
        check("rel_pc", pc_o, 32'h214);

        // bad canary words
        fe = mk(32'h00100493, 32'h1234, 32'd7, 4'h3);
        cyc();
        check("cerr_set", err_o, 1);
        check("cerr_pc1", err_pc_o, 32'h1234);
        check("cerr_noissue", valid_o, 0);
        fe = mk(32'h00100493, 32'h5678, 32'd8, 4'h3);
        cyc();
        check("cerr_pc_sticky", err_pc_o, 32'h1234);
        fe = '0;
        cyc();

        // async reset in mid cycle
        #2 reset = 1'b0;
        #1 check("async_cerr", err_o, 0);
        check("async_busy", busy_o, 0);
        cyc(2);
        reset = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de_fe_receiver.md
Name: de_fe_receiver

Overview:
- Decode-side receiver of the fetch-latch bus.
- Unpacks the packed FE latch word {inst, pc, pcplus, inst_count, canary} and validates it against the bus canary.
- Tracks register write-in-flight hazards with a 32-entry busy scoreboard.
- Drives the stall back to fetch and registers a decoded, valid-tagged DE output latch for AGEX.

Parameters:
- DBITS, 32, width of PC, pcplus and inst_count fields.
- INSTBITS, 32, instruction width.
- CANARY_BITS, 4, width of the bus canary field (LSBs of the latch word).
- CANARY_VALUE, 4'hA, expected canary value.
- FE_W, INSTBITS+3*DBITS+CANARY_BITS, fetch latch width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- fe_latch_in  in  FE_W  packed fetch latch, MSB-first order inst, pc, pcplus, inst_count, canary.
- agex_stall  in  1  downstream cannot accept the DE latch this cycle.
- agex_flush  in  1  branch/jump redirect resolved in AGEX; squash the DE-held instruction.
- wb_valid  in  1  writeback retiring a register write.
- wb_rd  in  5  writeback destination register.
- de_stall_to_fe  out  1  fetch must hold its latch.
- de_valid_out  out  1  DE latch holds a real instruction.
- de_inst_out  out  INSTBITS  instruction.
- de_pc_out  out  DBITS  PC.
- de_pcplus_out  out  DBITS  PC+4.
- de_count_out  out  DBITS  debug instruction count.
- de_rd_out  out  5  destination register.
- de_wr_out  out  1  instruction writes rd (rd != 0).
- canary_err  out  1  sticky bus-integrity error.
- canary_err_pc  out  DBITS  PC field of the first mismatching valid-looking word.
- busy_vec  out  32  scoreboard, for debug and bench.

Behaviour:
- Reset (reset=0, async): all outputs 0; busy_vec=0; DE latch is a bubble. Reset asserted mid-operation drops the held instruction immediately.
- Input valid rule: in_valid = (canary field == CANARY_VALUE). An all-zero word is a bubble and is not an error.
- Canary error: a nonzero word with a canary mismatch sets canary_err=1 and captures its PC field. This happens once; the flag is sticky until reset. The word is treated as a bubble.
- Field decode:
  - rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20], opcode = inst[6:0].
  - Writes rd for all opcodes except 0100011 (STORE) and 1100011 (BRANCH). Writes to x0 are ignored.
  - Uses rs1 unless opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - Uses rs2 for 0110011, 0100011 and 1100011.
- Hazard:
  - hazard = in_valid & ((use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2])).
  - busy_eff = busy_vec with bit wb_rd cleared when wb_valid. Same-cycle WB release counts as available.
  - Register x0 is never busy.
- Stall: de_stall_to_fe = (hazard | agex_stall) & ~agex_flush. It is combinational, same-cycle.
- Issue: issue = in_valid & ~hazard & ~agex_stall & ~agex_flush.
- DE latch update, 1-cycle latency, on each posedge clk:
  - If agex_flush: de_valid_out <= 0; other fields don't-care, held.
  - Else if agex_stall: hold all fields.
  - Else if issue: load all fields and set de_valid_out <= 1.
  - Else: de_valid_out <= 0 (bubble inserted on hazard).
- Scoreboard update per cycle:
  - Clear bit wb_rd if wb_valid.
  - Then set bit rd if issue & writes_rd & rd != 0.
  - When set and clear target the same register, set wins (new producer outstanding).
  - Bit 0 is forced to 0.
- Flush priority: flush > stall > issue. Flush squashes only the DE-held instruction. The fetch word present in a flush cycle is not issued.

Decomposition:
- Package de_fe_pkg:
  - Field offsets of the FE latch (INST_MSB, PC_MSB, ...).
  - Opcode constants: OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE.
  - CANARY_VALUE and CANARY_BITS.
  - A function for writes_rd/use_rs1/use_rs2.
- One sub-module: reg_scoreboard (32-bit busy vector, set/clear ports, async active-low reset, combinational busy_eff read of two sources).

Test Plan:
- Reset then fe_latch_in=0 for 5 cycles -> de_valid_out=0, canary_err=0, busy_vec=0, de_stall_to_fe=0.
- Issue `addi x5,x0,1` (0x00100293) at PC 0x200, canary 4'hA -> next cycle de_valid_out=1, de_pc_out=0x200, de_pcplus_out=0x204, de_rd_out=5, de_wr_out=1, busy_vec[5]=1.
- Follow with `add x6,x5,x5` (0x00528333) -> de_stall_to_fe=1 and a bubble until wb_valid=1, wb_rd=5. The add issues in the WB cycle (same-cycle release); busy_vec ends with bit6=1, bit5=0.
- Same cycle issue of an rd=7 writer and wb_valid=1, wb_rd=7 -> busy_vec[7]=1 afterwards.
- agex_flush=1 with agex_stall=1 and a valid DE latch -> de_valid_out=0 next cycle, de_stall_to_fe=0, no busy bit set.
- Word with canary 4'h3, PC 0x1234 -> canary_err=1 and canary_err_pc=0x1234, no issue. A later bad word at a different PC leaves canary_err_pc unchanged. Async reset asserted mid-cycle clears canary_err immediately.
